// File: rtl/updown_counter_mod_if.sv
// Control and status bundle for the up/down counter.
// The counter itself takes the slave side; whoever drives the count controls takes the master side.
interface updown_counter_mod_if #(
  parameter int WIDTH = 3
);

  logic             en;
  logic             m;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, m, load, load_val, clr_ovf,
    input  q, qbar, tc, wrap, ovf
  );

  modport slave (
    input  en, m, load, load_val, clr_ovf,
    output q, qbar, tc, wrap, ovf
  );

endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised synchronous up/down counter, counting modulo MAX_COUNT+1.
// Supports parallel load with clamping, count enable, and wrap or saturate at the limits.
// Status outputs: terminal count, a one-cycle wrap pulse, and a sticky overflow flag.
module updown_counter_mod #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 7,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_counter_mod_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_nextQ;
  logic             w_wrapEvt;
  logic             w_limitEvt;

  // Next count and event detection: load beats enable; at a limit, either wrap around or hold.
  always_comb begin
    w_nextQ    = r_q;
    w_wrapEvt  = 1'b0;
    w_limitEvt = 1'b0;
    if (bus.load) begin
      w_nextQ = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
    end else if (bus.en) begin
      if (bus.m) begin
        if (r_q == MAX_Q) begin
          if (SAT) begin
            w_limitEvt = 1'b1;
          end else begin
            w_nextQ   = '0;
            w_wrapEvt = 1'b1;
          end
        end else begin
          w_nextQ = r_q + ONE_Q;
        end
      end else begin
        if (r_q == '0) begin
          if (SAT) begin
            w_limitEvt = 1'b1;
          end else begin
            w_nextQ   = MAX_Q;
            w_wrapEvt = 1'b1;
          end
        end else begin
          w_nextQ = r_q - ONE_Q;
        end
      end
    end
  end

  // State registers; a new wrap or limit event takes precedence over a clear of ovf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= w_nextQ;
      r_wrap <= w_wrapEvt;
      if (w_wrapEvt || w_limitEvt) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.qbar = ~r_q;
  assign bus.tc   = bus.m ? (r_q == MAX_Q) : (r_q == '0);
  assign bus.wrap = r_wrap;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Testbench for updown_counter_mod.
// Runs four counter configurations side by side from shared stimulus and checks each against a
// modulo-arithmetic model.
module tb_updown_counter_mod;

  localparam int N = 4;
  localparam int PW[N] = '{3, 4, 3, 2};
  localparam int PM[N] = '{7, 9, 5, 0};
  localparam int PS[N] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       en = 1'b0, m = 1'b0, load = 1'b0, clr = 1'b0;
  logic [3:0] lv = 4'd0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  updown_counter_mod_if #(.WIDTH(3)) if0 ();
  updown_counter_mod_if #(.WIDTH(4)) if1 ();
  updown_counter_mod_if #(.WIDTH(3)) if2 ();
  updown_counter_mod_if #(.WIDTH(2)) if3 ();

  assign if0.en = en; assign if0.m = m; assign if0.load = load; assign if0.clr_ovf = clr; assign if0.load_val = lv[2:0];
  assign if1.en = en; assign if1.m = m; assign if1.load = load; assign if1.clr_ovf = clr; assign if1.load_val = lv[3:0];
  assign if2.en = en; assign if2.m = m; assign if2.load = load; assign if2.clr_ovf = clr; assign if2.load_val = lv[2:0];
  assign if3.en = en; assign if3.m = m; assign if3.load = load; assign if3.clr_ovf = clr; assign if3.load_val = lv[1:0];

  updown_counter_mod #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  updown_counter_mod #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  updown_counter_mod #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  updown_counter_mod #(.WIDTH(2), .MAX_COUNT(0), .SATURATE(0)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic [31:0] aq[N], aqb[N];
  logic        atc[N], awr[N], aov[N];

  assign aq[0] = 32'(if0.q); assign aqb[0] = 32'(if0.qbar); assign atc[0] = if0.tc; assign awr[0] = if0.wrap; assign aov[0] = if0.ovf;
  assign aq[1] = 32'(if1.q); assign aqb[1] = 32'(if1.qbar); assign atc[1] = if1.tc; assign awr[1] = if1.wrap; assign aov[1] = if1.ovf;
  assign aq[2] = 32'(if2.q); assign aqb[2] = 32'(if2.qbar); assign atc[2] = if2.tc; assign awr[2] = if2.wrap; assign aov[2] = if2.ovf;
  assign aq[3] = 32'(if3.q); assign aqb[3] = 32'(if3.qbar); assign atc[3] = if3.tc; assign awr[3] = if3.wrap; assign aov[3] = if3.ovf;

  int mq[N];
  bit mwrap[N];
  bit movf[N];

  // Reference model: count with modulo MAX+1 arithmetic, then undo the step if the config saturates.
  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < N; k++) begin
      int lvk;
      int nq;
      bit evt;
      if (!rst) begin
        mq[k]    = 0;
        mwrap[k] = 1'b0;
        movf[k]  = 1'b0;
      end else begin
        lvk = int'(lv) & ((1 << PW[k]) - 1);
        nq  = mq[k];
        evt = 1'b0;
        if (load) begin
          nq = (lvk > PM[k]) ? PM[k] : lvk;
        end else if (en) begin
          nq  = (mq[k] + (m ? 1 : PM[k])) % (PM[k] + 1);
          evt = m ? (mq[k] == PM[k]) : (mq[k] == 0);
          if (evt && PS[k] != 0) nq = mq[k];
        end
        mwrap[k] = evt && (PS[k] == 0);
        movf[k]  = evt ? 1'b1 : (clr ? 1'b0 : movf[k]);
        mq[k]    = nq;
      end
    end
  end

  // Compares one observed value with its expected value and records any miscompare.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every falling edge: all outputs of every configuration against the model.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic [31:0] mask;
      mask = (32'd1 << PW[k]) - 32'd1;
      checkOutput($sformatf("q[%0d]", k), aq[k], 32'(mq[k]));
      checkOutput($sformatf("qbar[%0d]", k), aqb[k], (~32'(mq[k])) & mask);
      checkOutput($sformatf("tc[%0d]", k), 32'(atc[k]), 32'(m ? (mq[k] == PM[k]) : (mq[k] == 0)));
      checkOutput($sformatf("wrap[%0d]", k), 32'(awr[k]), 32'(mwrap[k]));
      checkOutput($sformatf("ovf[%0d]", k), 32'(aov[k]), 32'(movf[k]));
    end
  end

  // Waits for the next rising edge, then sets up the inputs for the edge after it.
  task automatic applyStimulus(input bit e, input bit mm, input bit ld, input logic [3:0] v, input bit c);
    @(posedge clk);
    #2;
    en = e; m = mm; load = ld; lv = v; clr = c;
  endtask

  // Directed scenarios with hand-computed values, then a long randomized run.
  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #12;
    checkOutput("rst_q0", aq[0], 32'd0);
    checkOutput("rst_qbar0", aqb[0], 32'd7);
    @(posedge clk); #2 rst = 1'b1;

    // Nine enabled up-count edges.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("up9_q0", aq[0], 32'd1);
    checkOutput("up9_ovf0", 32'(aov[0]), 32'd1);
    checkOutput("up9_wrap0", 32'(awr[0]), 32'd0);
    checkOutput("up9_q1", aq[1], 32'd9);
    checkOutput("up9_ovf1", 32'(aov[1]), 32'd0);
    checkOutput("up9_q2", aq[2], 32'd5);
    checkOutput("up9_ovf2", 32'(aov[2]), 32'd1);
    checkOutput("up9_ovf3", 32'(aov[3]), 32'd1);

    // Load together with enable: the load wins, and 12 clamps to 9 on the mod-10 counter.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("load_q1", aq[1], 32'd9);
    checkOutput("load_q0", aq[0], 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("wrap_q1", aq[1], 32'd0);
    checkOutput("wrap_w1", 32'(awr[1]), 32'd1);
    checkOutput("wrap_q0", aq[0], 32'd5);

    // Asynchronous reset between edges.
    #3 rst = 1'b0;
    #1;
    checkOutput("arst_q0", aq[0], 32'd0);
    checkOutput("arst_qbar0", aqb[0], 32'd7);
    checkOutput("arst_ovf0", 32'(aov[0]), 32'd0);
    checkOutput("arst_wrap1", 32'(awr[1]), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("rel_q0", aq[0], 32'd1);

    // Event and clear on the same edge: the degenerate counter keeps ovf set.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("setclr_ovf3", 32'(aov[3]), 32'd1);
    checkOutput("setclr_tc3", 32'(atc[3]), 32'd1);
    checkOutput("down_q0", aq[0], 32'd0);

    // Randomized run; direction changes rarely so the limits get reached.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7,
                    ($urandom_range(0, 4) == 0) ? ~m : m,
                    $urandom_range(0, 11) == 0,
                    4'($urandom),
                    $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Fully synchronous, parametrised up/down counter.
- Successor to the 3-bit JK ripple up/down counter.
- Generalised to WIDTH bits and a programmable terminal value (MAX_COUNT).
- Adds parallel load, count enable, wrap/saturate mode, a terminal-count flag, a wrap pulse and a sticky overflow flag.
- Single clock domain, so outputs are glitch-free. Used as a general event/divider counter in the sequential-circuit library.

Parameters:
- WIDTH, 3, counter width in bits (1..32).
- MAX_COUNT, 7, highest count value. Range is 0..MAX_COUNT, giving modulus MAX_COUNT+1. Must be <= 2^WIDTH-1.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- en, input, 1, count enable.
- m, input, 1, direction: 1 = up, 0 = down.
- load, input, 1, synchronous parallel load.
- load_val, input, WIDTH, value to load.
- clr_ovf, input, 1, synchronous clear of ovf.
- q, output, WIDTH, count value (registered).
- qbar, output, WIDTH, bitwise inverse of q.
- tc, output, 1, terminal count (combinational from q and m).
- wrap, output, 1, one-cycle registered pulse.
- ovf, output, 1, sticky overflow/underflow flag (registered).

Behaviour:
- Reset: one clock, clk. Reset rst is asynchronous and active-low. rst=0 immediately forces q=0, qbar=all 1s, wrap=0, ovf=0, independent of clk. Counting resumes on the first rising edge after rst returns to 1.
- Priority at each rising edge: load > en. Neither asserted: q holds.
- load=1:
  - q <= load_val when load_val <= MAX_COUNT, else q <= MAX_COUNT (clamp).
  - No wrap pulse; ovf not set by load.
- en=1, load=0, m=1 (up):
  - q < MAX_COUNT: q <= q+1.
  - q == MAX_COUNT: SATURATE=0 gives q <= 0 (wrap event). SATURATE=1 holds q (limit event).
- en=1, load=0, m=0 (down):
  - q > 0: q <= q-1.
  - q == 0: SATURATE=0 gives q <= MAX_COUNT (wrap event). SATURATE=1 holds q (limit event).
- Direction changes take effect on the same edge m is sampled. No dead cycle.
- Arithmetic is modulo MAX_COUNT+1, not 2^WIDTH. q never exceeds MAX_COUNT after any edge.
- qbar = ~q at all times, including during reset.
- tc = 1 when (m=1 and q==MAX_COUNT) or (m=0 and q==0). It is independent of en, so it can gate a cascaded stage's en.
- wrap = 1 for exactly the one cycle following an edge that performed a wrap event; 0 otherwise. Always 0 when SATURATE=1.
- ovf:
  - Set on the edge of any wrap or limit event.
  - Cleared by clr_ovf=1.
  - Set and clear on the same edge: set wins, ovf stays 1.
- Degenerate case MAX_COUNT=0: q stays 0, tc=1 in both directions. Every enabled edge is a wrap/limit event.

Test Plan:
1. WIDTH=3, MAX_COUNT=7, SATURATE=0; rst=0 then 1; en=1, m=1 for 9 edges -> q = 1,2,...,7,0,1. wrap high for the one cycle after the 7->0 edge. ovf=1 afterwards. tc=1 only while q=7.
2. Same config, q=2, m=0 for 3 edges -> q = 1,0,7. tc=1 while q=0. wrap pulse after the 0->7 edge. clr_ovf=1 for one edge -> ovf=0.
3. MAX_COUNT=9 (WIDTH=4): load=1, load_val=12 -> q=9. Then en=1, m=1 -> q=0, wrap pulse. load_val=5 with load=1 and en=1 on the same edge -> q=5 (load wins).
4. SATURATE=1, MAX_COUNT=5: count up from 3 for 4 edges -> q = 4,5,5,5. wrap stays 0, ovf=1. Then m=0 from q=0 -> q stays 0, ovf stays set.
5. Mid-count at q=6, pull rst low between edges -> q=0, qbar=111, ovf=0, wrap=0 immediately, without waiting for a clock edge. Release -> next enabled up edge gives q=1.
6. ovf=1, trigger a wrap event with clr_ovf=1 on the same edge -> ovf remains 1. Toggle m each edge from q=3 -> q = 4,3,4,3.
